// File: rtl/nmr_bstrm_sram_arb_if.sv
// Signal bundle around the bitstream command SRAM arbiter: sequencer port (A),
// host port (B) and the single-port SRAM side, plus a debug view of the starve counter.
interface nmr_bstrm_sram_arb_if #(
    parameter int SRAM_ADDR_WIDTH = 8,
    parameter int SRAM_DAT_WIDTH  = 128
);
    // Handshake: a requester raises REQ with its payload and holds both stable until
    // the matching one-cycle GNT; each granted read returns exactly one RVALID pulse,
    // in issue order, and RDAT holds between pulses.
    logic                       a_req;
    logic [SRAM_ADDR_WIDTH-1:0] a_addr;
    logic                       a_gnt;
    logic [SRAM_DAT_WIDTH-1:0]  a_rdat;
    logic                       a_rvalid;

    logic                       b_req;
    logic                       b_we;
    logic [SRAM_ADDR_WIDTH-1:0] b_addr;
    logic [SRAM_DAT_WIDTH-1:0]  b_wdat;
    logic                       b_gnt;
    logic                       b_err;
    logic [SRAM_DAT_WIDTH-1:0]  b_rdat;
    logic                       b_rvalid;

    logic                       seq_busy;

    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic                       sram_cs;
    logic                       sram_we;
    logic [SRAM_DAT_WIDTH-1:0]  sram_wr_dat;
    logic [SRAM_DAT_WIDTH-1:0]  sram_rd_dat;

    logic [7:0]                 starve_cnt;

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdat, seq_busy, sram_rd_dat,
        output a_gnt, a_rdat, a_rvalid, b_gnt, b_err, b_rdat, b_rvalid,
        output sram_addr, sram_cs, sram_we, sram_wr_dat, starve_cnt
    );

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdat, seq_busy, sram_rd_dat,
        input  a_gnt, a_rdat, a_rvalid, b_gnt, b_err, b_rdat, b_rvalid,
        input  sram_addr, sram_cs, sram_we, sram_wr_dat, starve_cnt
    );
endinterface

// File: rtl/nmr_bstrm_sram_arb.sv
// Shares the single-port bitstream SRAM between the sequencer (read-only) and the host
// loader; registers the SRAM strobes and steers returning read data back to its issuer.
module nmr_bstrm_sram_arb #(
    parameter int SRAM_ADDR_WIDTH = 8,
    parameter int SRAM_DAT_WIDTH  = 128,
    parameter int RD_LAT          = 2,
    parameter int STARVE_MAX      = 8
) (
    input logic                 clk,
    input logic                 rst,
    nmr_bstrm_sram_arb_if.slave bus
);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef struct packed {
        logic valid;
        logic owner_b;
    } tag_t;

    tag_t [RD_LAT:0] tag_pipe;
    tag_t            tag_new;
    tag_t            tag_tail;

    logic a_elig;
    logic b_elig;
    logic b_refuse;
    logic b_access;
    logic b_win;
    logic a_win;

    // A requester whose GNT is high this cycle is not eligible again until the next edge.
    assign a_elig   = bus.a_req && !bus.a_gnt;
    assign b_elig   = bus.b_req && !bus.b_gnt;
    // Refused host writes never touch the SRAM, so they cannot block the sequencer.
    assign b_refuse = b_elig && bus.b_we && bus.seq_busy;
    assign b_access = b_elig && !b_refuse;
    assign b_win    = b_access && (!a_elig || (bus.starve_cnt == STARVE_LIM));
    assign a_win    = a_elig && !b_win;

    assign tag_new  = {a_win || (b_win && !bus.b_we), b_win};
    assign tag_tail = tag_pipe[RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.a_gnt       <= 1'b0;
            bus.b_gnt       <= 1'b0;
            bus.b_err       <= 1'b0;
            bus.sram_cs     <= 1'b0;
            bus.sram_we     <= 1'b0;
            bus.sram_addr   <= '0;
            bus.sram_wr_dat <= '0;
            bus.a_rvalid    <= 1'b0;
            bus.b_rvalid    <= 1'b0;
            bus.a_rdat      <= '0;
            bus.b_rdat      <= '0;
            bus.starve_cnt  <= '0;
            tag_pipe        <= '0;
        end else begin
            bus.a_gnt   <= a_win;
            bus.b_gnt   <= b_win || b_refuse;
            bus.b_err   <= b_refuse;
            bus.sram_cs <= a_win || b_win;
            bus.sram_we <= b_win && bus.b_we;

            if (b_win) begin
                bus.sram_addr   <= bus.b_addr;
                bus.sram_wr_dat <= bus.b_wdat;
            end else if (a_win) begin
                bus.sram_addr <= bus.a_addr;
            end

            if (b_win || b_refuse) begin
                bus.starve_cnt <= '0;
            end else if (b_access && (bus.starve_cnt != STARVE_LIM)) begin
                bus.starve_cnt <= bus.starve_cnt + 8'd1;
            end

            // Tail of the tag pipe lines up with the cycle SRAM_RD_DAT is valid.
            tag_pipe     <= {tag_pipe[RD_LAT-1:0], tag_new};
            bus.a_rvalid <= tag_tail.valid && !tag_tail.owner_b;
            bus.b_rvalid <= tag_tail.valid && tag_tail.owner_b;
            if (tag_tail.valid && !tag_tail.owner_b) begin
                bus.a_rdat <= bus.sram_rd_dat;
            end
            if (tag_tail.valid && tag_tail.owner_b) begin
                bus.b_rdat <= bus.sram_rd_dat;
            end
        end
    end
endmodule

// File: tb/tb_nmr_bstrm_sram_arb.sv
// Bench for the bitstream SRAM arbiter: behavioural SRAM, cycle-level reference model
// with a scheduled-return map, directed steps followed by randomized traffic.
module tb_nmr_bstrm_sram_arb;
    localparam int AW         = 8;
    localparam int DW         = 128;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nmr_bstrm_sram_arb_if #(.SRAM_ADDR_WIDTH(AW), .SRAM_DAT_WIDTH(DW)) bus ();

    nmr_bstrm_sram_arb #(
        .SRAM_ADDR_WIDTH(AW),
        .SRAM_DAT_WIDTH (DW),
        .RD_LAT         (RD_LAT),
        .STARVE_MAX     (STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        logic [31:0] h;
        if (i == 5) return {1'b1, 126'd0, 1'b1};
        h = 32'(i) * 32'h9E37_79B1;
        return {h, ~h, h ^ 32'h5A5A_A5A5, 32'(i)};
    endfunction

    // Behavioural single-port SRAM; data is valid RD_LAT cycles after the CS cycle,
    // junk otherwise so a mistimed capture shows up.
    logic [DW-1:0] sram_mem [0:255];
    logic [DW-1:0] rd_dly   [0:RD_LAT-1];

    always @(posedge clk) begin
        if (bus.sram_cs && bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wr_dat;
        rd_dly[0] <= (bus.sram_cs && !bus.sram_we) ? sram_mem[bus.sram_addr]
                                                    : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < RD_LAT; i++) rd_dly[i] <= rd_dly[i-1];
        if (rst) for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
    end
    assign bus.sram_rd_dat = rd_dly[RD_LAT-1];

    // Reference model state
    logic [DW-1:0] exp_mem [0:255];
    int            cyc;
    int            a_gnt_cyc;
    int            b_gnt_cyc;
    int            b_wait;
    bit            e_a_gnt, e_b_gnt, e_b_err, e_cs, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdat, e_a_rdat, e_b_rdat;
    bit            ret_b   [int];
    logic [DW-1:0] ret_dat [int];
    int            total;
    int            bad;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_a_gnt = 0; e_b_gnt = 0; e_b_err = 0; e_cs = 0; e_we = 0;
        e_addr = '0; e_wdat = '0; e_a_rdat = '0; e_b_rdat = '0;
        b_wait = 0; a_gnt_cyc = -10; b_gnt_cyc = -10;
        ret_b.delete();
        ret_dat.delete();
        for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    endtask

    // Predicts the edge that ends cycle cyc from the inputs currently driven.
    task automatic model_edge();
        bit ae, be, bref, bacc, bwin, awin;
        int k;
        if (rst) begin
            model_reset();
            return;
        end
        k    = cyc + 2 + RD_LAT;
        ae   = bus.a_req && (a_gnt_cyc != cyc);
        be   = bus.b_req && (b_gnt_cyc != cyc);
        bref = be && bus.b_we && bus.seq_busy;
        bacc = be && !bref;
        bwin = bacc && (!ae || b_wait == STARVE_MAX);
        awin = ae && !bwin;
        if (bwin || bref) b_wait = 0;
        else if (bacc) b_wait = (b_wait < STARVE_MAX) ? b_wait + 1 : STARVE_MAX;
        e_a_gnt = awin;
        e_b_gnt = bwin || bref;
        e_b_err = bref;
        e_cs    = awin || bwin;
        e_we    = bwin && bus.b_we;
        if (awin) a_gnt_cyc = cyc + 1;
        if (e_b_gnt) b_gnt_cyc = cyc + 1;
        if (bwin) begin
            e_addr = bus.b_addr;
            e_wdat = bus.b_wdat;
            if (bus.b_we) exp_mem[bus.b_addr] = bus.b_wdat;
            else begin
                ret_b[k]   = 1'b1;
                ret_dat[k] = exp_mem[bus.b_addr];
            end
        end else if (awin) begin
            e_addr     = bus.a_addr;
            ret_b[k]   = 1'b0;
            ret_dat[k] = exp_mem[bus.a_addr];
        end
    endtask

    task automatic check_cycle();
        bit ea, eb;
        ea = ret_b.exists(cyc) && !ret_b[cyc];
        eb = ret_b.exists(cyc) && ret_b[cyc];
        if (ea) e_a_rdat = ret_dat[cyc];
        if (eb) e_b_rdat = ret_dat[cyc];
        chk("a_gnt",      DW'(bus.a_gnt),    DW'(e_a_gnt));
        chk("b_gnt",      DW'(bus.b_gnt),    DW'(e_b_gnt));
        chk("b_err",      DW'(bus.b_err),    DW'(e_b_err));
        chk("sram_cs",    DW'(bus.sram_cs),  DW'(e_cs));
        chk("sram_we",    DW'(bus.sram_we),  DW'(e_we));
        chk("sram_addr",  DW'(bus.sram_addr), DW'(e_addr));
        if (e_we) chk("sram_wr_dat", bus.sram_wr_dat, e_wdat);
        chk("a_rvalid",   DW'(bus.a_rvalid), DW'(ea));
        chk("b_rvalid",   DW'(bus.b_rvalid), DW'(eb));
        chk("a_rdat",     bus.a_rdat, e_a_rdat);
        chk("b_rdat",     bus.b_rdat, e_b_rdat);
        chk("starve_cnt", DW'(bus.starve_cnt), DW'(b_wait));
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
        cyc++;
        check_cycle();
    endtask

    task automatic idle(input int n);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic a_read(input logic [AW-1:0] addr);
        bus.a_req  = 1'b1;
        bus.a_addr = addr;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (e_a_gnt) begin
                bus.a_req = 1'b0;
                return;
            end
        end
        total++; bad++;
        $error("FAIL a_read_timeout got=no_gnt want=gnt");
        bus.a_req = 1'b0;
    endtask

    task automatic b_op(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdat,
                        input bit busy);
        bus.b_req    = 1'b1;
        bus.b_we     = we;
        bus.b_addr   = addr;
        bus.b_wdat   = wdat;
        bus.seq_busy = busy;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (e_b_gnt) begin
                bus.b_req = 1'b0;
                return;
            end
        end
        total++; bad++;
        $error("FAIL b_op_timeout got=no_gnt want=gnt");
        bus.b_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rv_seen;
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1;
        bus.a_req = 1'b0; bus.a_addr = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdat = '0;
        bus.seq_busy = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check_cycle();
        chk("rst_wr_dat", bus.sram_wr_dat, '0);
        rst = 1'b0;

        // Sequencer read of word 5, returns RD_LAT+2 cycles after the request edge
        a_read(8'h05);
        idle(RD_LAT + 3);
        chk("a5_rdat", bus.a_rdat, {1'b1, 126'd0, 1'b1});

        // Host write then readback while idle
        b_op(1'b1, 8'h10, 128'hDEAD, 1'b0);
        b_op(1'b0, 8'h10, '0, 1'b0);
        idle(RD_LAT + 3);
        chk("b10_rdat", bus.b_rdat, 128'hDEAD);

        // Refused write while the sequence runs leaves the word intact
        b_op(1'b1, 8'h10, 128'hBEEF, 1'b1);
        b_op(1'b0, 8'h10, '0, 1'b0);
        idle(RD_LAT + 3);
        chk("b10_after_refuse", bus.b_rdat, 128'hDEAD);

        // A read alongside a refused B write: both granted in the same cycle
        bus.a_req = 1'b1; bus.a_addr = 8'h07;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h07; bus.seq_busy = 1'b1;
        tick();
        chk("both_gnt", DW'({bus.a_gnt, bus.b_gnt, bus.b_err}), DW'(3'b111));
        idle(RD_LAT + 3);
        bus.seq_busy = 1'b0;

        // Both requesters holding REQ continuously
        bus.a_req = 1'b1; bus.a_addr = 8'h01;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h02;
        repeat (40) tick();
        idle(RD_LAT + 3);

        // Back-to-back alternating reads with fresh random addresses after each grant
        bus.a_req = 1'b1; bus.b_req = 1'b1; bus.b_we = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (e_a_gnt) bus.a_addr = AW'($urandom_range(0, 255));
            if (e_b_gnt) bus.b_addr = AW'($urandom_range(0, 255));
        end
        idle(RD_LAT + 3);

        // Mixed random traffic on a small address window to provoke read-after-write
        for (int n = 0; n < 400; n++) begin
            if (!bus.a_req || e_a_gnt) begin
                bus.a_req  = ($urandom_range(0, 2) != 0);
                bus.a_addr = AW'($urandom_range(0, 15));
            end
            if (!bus.b_req || e_b_gnt) begin
                bus.b_req  = ($urandom_range(0, 2) != 0);
                bus.b_we   = $urandom_range(0, 1) != 0;
                bus.b_addr = AW'($urandom_range(0, 15));
                bus.b_wdat = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.seq_busy = ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.seq_busy = 1'b0;
        idle(RD_LAT + 3);

        // Reset with two reads in flight: nothing may return afterwards
        bus.a_req = 1'b1; bus.a_addr = 8'h03;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h04;
        tick();
        tick();
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_rdat", bus.a_rdat | bus.b_rdat | bus.sram_wr_dat, '0);
        rv_seen = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            rv_seen += int'(bus.a_rvalid) + int'(bus.b_rvalid);
        end
        chk("post_rst_rvalid", DW'(rv_seen), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
